// File: rtl/zap_bp_pkg.sv
// Shared types and constants for the gshare branch predictor:
// counter encodings, FSM states and the counter init-value helper.
package zap_bp_pkg;

   localparam int unsigned CTR_W_MAX = 4;

   typedef enum logic [1:0] {
      SNT = 2'd0,
      WNT = 2'd1,
      WT  = 2'd2,
      ST  = 2'd3
   } ctr2_e;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } bp_state_e;

   // Weakly-not-taken value for a counter of width w (0 for 1-bit counters).
   function automatic logic [CTR_W_MAX-1:0] ctr_weak_nt(input int unsigned w);
      if (w <= 1) return '0;
      return CTR_W_MAX'((1 << (w - 1)) - 1);
   endfunction

endpackage

// File: rtl/zap_branch_predict_gshare_if.sv
// Fetch payload, resolved-branch update and registered prediction bundle.
// master = pipeline side, slave = predictor side.
interface zap_branch_predict_gshare_if #(
   parameter int unsigned IDX_W = 9
);
   logic [31:0]      i_pc;
   logic [31:0]      i_inst;
   logic [31:0]      i_pc_plus_8;
   logic             i_val;
   logic             i_abt;
   logic             i_upd_valid;
   logic [IDX_W-1:0] i_upd_index;
   logic             i_upd_taken;

   logic [31:0]      o_inst_ff;
   logic [31:0]      o_pc_plus_8_ff;
   logic             o_val_ff;
   logic             o_abt_ff;
   logic             o_taken_ff;
   logic [IDX_W-1:0] o_index_ff;

   modport master (
      output i_pc, i_inst, i_pc_plus_8, i_val, i_abt,
             i_upd_valid, i_upd_index, i_upd_taken,
      input  o_inst_ff, o_pc_plus_8_ff, o_val_ff, o_abt_ff, o_taken_ff, o_index_ff
   );

   modport slave (
      input  i_pc, i_inst, i_pc_plus_8, i_val, i_abt,
             i_upd_valid, i_upd_index, i_upd_taken,
      output o_inst_ff, o_pc_plus_8_ff, o_val_ff, o_abt_ff, o_taken_ff, o_index_ff
   );
endinterface

// File: rtl/zap_bp_counter_ram.sv
// Saturating-counter table: one combinational lookup port and one write port
// that either sweeps in the init value or applies a saturating update.
module zap_bp_counter_ram
   import zap_bp_pkg::*;
#(
   parameter int unsigned ENTRIES = 512,
   parameter int unsigned CTR_W   = 2
) (
   input  logic                       clk_i,
   input  logic [$clog2(ENTRIES)-1:0] rd_idx_i,
   output logic [CTR_W-1:0]           rd_ctr_o,
   input  logic                       sweep_en_i,
   input  logic [$clog2(ENTRIES)-1:0] sweep_idx_i,
   input  logic                       upd_en_i,
   input  logic [$clog2(ENTRIES)-1:0] upd_idx_i,
   input  logic                       upd_taken_i
);
   localparam logic [CTR_W-1:0] CTR_MAX  = '1;
   localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_weak_nt(CTR_W));

   logic [CTR_W-1:0] mem_q [ENTRIES];
   logic [CTR_W-1:0] upd_old_c;
   logic [CTR_W-1:0] upd_new_c;

   assign rd_ctr_o  = mem_q[rd_idx_i];
   assign upd_old_c = mem_q[upd_idx_i];

   always_comb begin
      upd_new_c = upd_old_c;
      if (upd_taken_i && (upd_old_c != CTR_MAX)) begin
         upd_new_c = upd_old_c + CTR_W'(1);
      end else if (!upd_taken_i && (upd_old_c != '0)) begin
         upd_new_c = upd_old_c - CTR_W'(1);
      end
   end

   // Contents are deliberately unreset; the init sweep rewrites every entry.
   always_ff @(posedge clk_i) begin
      if (sweep_en_i) begin
         mem_q[sweep_idx_i] <= CTR_INIT;
      end else if (upd_en_i) begin
         mem_q[upd_idx_i] <= upd_new_c;
      end
   end

endmodule

// File: rtl/zap_branch_predict_gshare.sv
// Gshare branch predictor stage: indexes a counter table with PC ^ history,
// registers the fetch payload with its prediction, and sweeps the table on init.
module zap_branch_predict_gshare
   import zap_bp_pkg::*;
#(
   parameter int unsigned ENTRIES = 512,
   parameter int unsigned CTR_W   = 2,
   parameter int unsigned HIST_W  = 8,
   parameter int unsigned GSHARE  = 1
) (
   input  logic                       i_clk,
   input  logic                       i_reset_n,
   input  logic                       i_clear_from_writeback,
   input  logic                       i_data_stall,
   input  logic                       i_clear_from_alu,
   input  logic                       i_stall_from_shifter,
   input  logic                       i_stall_from_issue,
   input  logic                       i_stall_from_decode,
   input  logic                       i_clear_from_decode,
   input  logic                       i_flush_table,
   zap_branch_predict_gshare_if.slave bus,
   output logic                       o_init_busy
);
   localparam int unsigned IDX_W   = $clog2(ENTRIES);
   localparam logic [31:0] CLR_PC8 = 32'd8;

   bp_state_e        state_q;
   logic             busy_q;
   logic [IDX_W-1:0] sweep_q;
   logic [IDX_W-1:0] hist_c;
   logic [IDX_W-1:0] idx_c;
   logic [CTR_W-1:0] rd_ctr_c;
   logic             sweep_en_c;
   logic             upd_en_c;
   logic             hold_c;
   logic             clr_c;
   logic             ld_c;
   logic             unused_pc_c;

   logic [31:0]      inst_q, inst_d;
   logic [31:0]      pc8_q, pc8_d;
   logic             val_q, val_d;
   logic             abt_q, abt_d;
   logic             taken_q, taken_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   assign unused_pc_c = ^{bus.i_pc[31:IDX_W+1], bus.i_pc[0]};
   assign sweep_en_c  = (state_q == INIT);
   assign upd_en_c    = bus.i_upd_valid & ~i_data_stall & (state_q == READY);
   assign idx_c       = bus.i_pc[IDX_W:1] ^ ((GSHARE != 0) ? hist_c : '0);

   // Global history; held at zero while the table is being initialised.
   generate
      if (HIST_W > 0) begin : g_ghr
         logic [HIST_W-1:0] ghr_q;
         always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
               ghr_q <= '0;
            end else if (state_q == INIT) begin
               ghr_q <= '0;
            end else if (upd_en_c) begin
               ghr_q <= HIST_W'({ghr_q, bus.i_upd_taken});
            end
         end
         assign hist_c = IDX_W'(ghr_q);
      end else begin : g_no_ghr
         assign hist_c = '0;
      end
   endgenerate

   zap_bp_counter_ram #(
      .ENTRIES (ENTRIES),
      .CTR_W   (CTR_W)
   ) u_ram (
      .clk_i       (i_clk),
      .rd_idx_i    (idx_c),
      .rd_ctr_o    (rd_ctr_c),
      .sweep_en_i  (sweep_en_c),
      .sweep_idx_i (sweep_q),
      .upd_en_i    (upd_en_c),
      .upd_idx_i   (bus.i_upd_index),
      .upd_taken_i (bus.i_upd_taken)
   );

   // Init sweep FSM; a flush in either state restarts the sweep at entry 0.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= INIT;
         sweep_q <= '0;
         busy_q  <= 1'b1;
      end else begin
         case (state_q)
            INIT: begin
               if (i_flush_table) begin
                  sweep_q <= '0;
               end else if (sweep_q == IDX_W'(ENTRIES - 1)) begin
                  state_q <= READY;
                  busy_q  <= 1'b0;
               end else begin
                  sweep_q <= sweep_q + IDX_W'(1);
               end
            end
            READY: begin
               if (i_flush_table) begin
                  state_q <= INIT;
                  sweep_q <= '0;
                  busy_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= INIT;
               sweep_q <= '0;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

   // Pipeline-control priority: wb clear, data stall, alu clear, stalls, decode clear, load.
   always_comb begin
      inst_d  = inst_q;
      pc8_d   = pc8_q;
      val_d   = val_q;
      abt_d   = abt_q;
      taken_d = taken_q;
      idx_d   = idx_q;
      clr_c   = 1'b0;
      ld_c    = 1'b0;
      hold_c  = i_stall_from_shifter | i_stall_from_issue | i_stall_from_decode;

      if (i_clear_from_writeback) begin
         clr_c = 1'b1;
      end else if (!i_data_stall) begin
         if (i_clear_from_alu) begin
            clr_c = 1'b1;
         end else if (!hold_c) begin
            if (i_clear_from_decode) clr_c = 1'b1;
            else                     ld_c  = 1'b1;
         end
      end

      if (clr_c) begin
         inst_d  = '0;
         pc8_d   = CLR_PC8;
         val_d   = 1'b0;
         abt_d   = 1'b0;
         taken_d = 1'b0;
         idx_d   = '0;
      end else if (ld_c) begin
         inst_d  = bus.i_inst;
         pc8_d   = bus.i_pc_plus_8;
         val_d   = bus.i_val & ~busy_q;
         abt_d   = bus.i_abt;
         taken_d = rd_ctr_c[CTR_W-1] & ~busy_q;
         idx_d   = idx_c;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         inst_q  <= '0;
         pc8_q   <= CLR_PC8;
         val_q   <= 1'b0;
         abt_q   <= 1'b0;
         taken_q <= 1'b0;
         idx_q   <= '0;
      end else begin
         inst_q  <= inst_d;
         pc8_q   <= pc8_d;
         val_q   <= val_d;
         abt_q   <= abt_d;
         taken_q <= taken_d;
         idx_q   <= idx_d;
      end
   end

   assign bus.o_inst_ff      = inst_q;
   assign bus.o_pc_plus_8_ff = pc8_q;
   assign bus.o_val_ff       = val_q;
   assign bus.o_abt_ff       = abt_q;
   assign bus.o_taken_ff     = taken_q;
   assign bus.o_index_ff     = idx_q;
   assign o_init_busy        = busy_q;

endmodule

// File: tb/tb_zap_branch_predict_gshare.sv
// Directed bench for the gshare predictor: dut0 is PC-indexed 2-bit,
// dut1 is gshare with 4-bit history and 3-bit counters; controls are shared.
module tb_zap_branch_predict_gshare;

   logic clk = 1'b0;
   logic rst_n;
   logic clr_wb, dstall, clr_alu, st_shf, st_iss, st_dec, clr_dec, flush;
   logic busy0, busy1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   zap_branch_predict_gshare_if #(.IDX_W(9)) bus0 ();
   zap_branch_predict_gshare_if #(.IDX_W(9)) bus1 ();

   zap_branch_predict_gshare #(
      .ENTRIES(512), .CTR_W(2), .HIST_W(8), .GSHARE(0)
   ) u_dut0 (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_clear_from_writeback(clr_wb), .i_data_stall(dstall),
      .i_clear_from_alu(clr_alu), .i_stall_from_shifter(st_shf),
      .i_stall_from_issue(st_iss), .i_stall_from_decode(st_dec),
      .i_clear_from_decode(clr_dec), .i_flush_table(flush),
      .bus(bus0), .o_init_busy(busy0)
   );

   zap_branch_predict_gshare #(
      .ENTRIES(512), .CTR_W(3), .HIST_W(4), .GSHARE(1)
   ) u_dut1 (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_clear_from_writeback(clr_wb), .i_data_stall(dstall),
      .i_clear_from_alu(clr_alu), .i_stall_from_shifter(st_shf),
      .i_stall_from_issue(st_iss), .i_stall_from_decode(st_dec),
      .i_clear_from_decode(clr_dec), .i_flush_table(flush),
      .bus(bus1), .o_init_busy(busy1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int n = 0;
      int bad_val = 0;
      rst_n = 1'b0;
      bus0.i_val = 1'b1; bus0.i_inst = 32'hDEAD_BEEF;
      bus0.i_pc = 32'h100; bus0.i_pc_plus_8 = 32'h108;
      bus1.i_val = 1'b1; bus1.i_inst = 32'h0; bus1.i_pc = 32'h0; bus1.i_pc_plus_8 = 32'h8;
      step(); step();
      checks++; if (bus0.o_inst_ff !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp 0", bus0.o_inst_ff); end
      checks++; if (bus0.o_pc_plus_8_ff !== 32'h8) begin errors++; $display("FAIL reset_pc8 got %h exp 8", bus0.o_pc_plus_8_ff); end
      checks++; if (bus0.o_val_ff !== 1'b0 || bus0.o_abt_ff !== 1'b0 || bus0.o_taken_ff !== 1'b0) begin
         errors++; $display("FAIL reset_flags got val=%b abt=%b tk=%b exp 0", bus0.o_val_ff, bus0.o_abt_ff, bus0.o_taken_ff); end
      checks++; if (bus0.o_index_ff !== 9'h0) begin errors++; $display("FAIL reset_index got %h exp 0", bus0.o_index_ff); end
      checks++; if (busy0 !== 1'b1 || busy1 !== 1'b1) begin errors++; $display("FAIL reset_busy got %b/%b exp 1/1", busy0, busy1); end
      rst_n = 1'b1;
      while (busy0 === 1'b1 && n < 1000) begin
         step(); n++;
         if (bus0.o_val_ff !== 1'b0) bad_val++;
      end
      checks++; if (n != 512) begin errors++; $display("FAIL init_len got %0d exp 512", n); end
      checks++; if (bad_val != 0) begin errors++; $display("FAIL init_val_leak got %0d exp 0", bad_val); end
      checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL init_busy1 got %b exp 0", busy1); end
      step();
      checks++; if (bus0.o_val_ff !== 1'b1 || bus0.o_inst_ff !== 32'hDEAD_BEEF || bus0.o_pc_plus_8_ff !== 32'h108) begin
         errors++; $display("FAIL first_load got val=%b inst=%h pc8=%h exp 1 deadbeef 108", bus0.o_val_ff, bus0.o_inst_ff, bus0.o_pc_plus_8_ff); end
   endtask

   task automatic test_gshare_off();
      bus0.i_pc = 32'h10C; bus0.i_inst = 32'hE12F_FF1E; bus0.i_pc_plus_8 = 32'h114;
      bus0.i_upd_valid = 1'b1; bus0.i_upd_index = 9'h086; bus0.i_upd_taken = 1'b1;
      step();
      checks++; if (bus0.o_taken_ff !== 1'b0 || bus0.o_index_ff !== 9'h086) begin
         errors++; $display("FAIL same_cycle_old got tk=%b idx=%h exp 0 086", bus0.o_taken_ff, bus0.o_index_ff); end
      step();
      checks++; if (bus0.o_taken_ff !== 1'b1) begin errors++; $display("FAIL ctr2_predict got %b exp 1", bus0.o_taken_ff); end
      step();
      bus0.i_upd_valid = 1'b0;
      step();
      checks++; if (bus0.o_taken_ff !== 1'b1 || bus0.o_index_ff !== 9'h086 || bus0.o_pc_plus_8_ff !== 32'h114) begin
         errors++; $display("FAIL sat_hi_lookup got tk=%b idx=%h pc8=%h exp 1 086 114", bus0.o_taken_ff, bus0.o_index_ff, bus0.o_pc_plus_8_ff); end
      bus0.i_upd_valid = 1'b1; bus0.i_upd_taken = 1'b0;
      step();
      bus0.i_upd_valid = 1'b0;
      step();
      checks++; if (bus0.o_taken_ff !== 1'b1) begin errors++; $display("FAIL sat_hi_dec got %b exp 1", bus0.o_taken_ff); end
   endtask

   task automatic test_saturation_low();
      bus0.i_pc = 32'h80;
      bus0.i_upd_valid = 1'b1; bus0.i_upd_index = 9'h040; bus0.i_upd_taken = 1'b0;
      step(); step(); step();
      bus0.i_upd_taken = 1'b1;
      step(); step();
      checks++; if (bus0.o_taken_ff !== 1'b0) begin errors++; $display("FAIL sat_lo_mid got %b exp 0", bus0.o_taken_ff); end
      bus0.i_upd_valid = 1'b0;
      step();
      checks++; if (bus0.o_taken_ff !== 1'b1 || bus0.o_index_ff !== 9'h040) begin
         errors++; $display("FAIL sat_lo got tk=%b idx=%h exp 1 040", bus0.o_taken_ff, bus0.o_index_ff); end
   endtask

   task automatic test_history();
      logic [3:0] tk;
      logic [8:0] exp_idx [5];
      tk = 4'b1101;
      exp_idx[0] = 9'h010; exp_idx[1] = 9'h011; exp_idx[2] = 9'h012; exp_idx[3] = 9'h015; exp_idx[4] = 9'h01B;
      bus1.i_pc = 32'h20; bus1.i_upd_index = 9'h033; bus1.i_upd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) bus1.i_upd_valid = 1'b0;
         else bus1.i_upd_taken = tk[i];
         step();
         checks++; if (bus1.o_index_ff !== exp_idx[i]) begin
            errors++; $display("FAIL ghr_index_%0d got %h exp %h", i, bus1.o_index_ff, exp_idx[i]); end
      end
      bus1.i_upd_valid = 1'b1; bus1.i_upd_index = 9'h055; bus1.i_upd_taken = 1'b1;
      for (int i = 0; i < 5; i++) step();
      bus1.i_upd_taken = 1'b0;
      step();
      bus1.i_upd_valid = 1'b0; bus1.i_pc = 32'hB6;
      step();
      checks++; if (bus1.o_index_ff !== 9'h055 || bus1.o_taken_ff !== 1'b1) begin
         errors++; $display("FAIL ctr3_sat got idx=%h tk=%b exp 055 1", bus1.o_index_ff, bus1.o_taken_ff); end
   endtask

   task automatic test_data_stall();
      bus0.i_pc = 32'h10C; bus0.i_inst = 32'h1111_1111;
      step();
      dstall = 1'b1; clr_alu = 1'b1;
      bus0.i_inst = 32'h2222_2222;
      bus0.i_upd_valid = 1'b1; bus0.i_upd_index = 9'h086; bus0.i_upd_taken = 1'b0;
      bus1.i_upd_valid = 1'b1; bus1.i_upd_index = 9'h055; bus1.i_upd_taken = 1'b0;
      step(); step();
      checks++; if (bus0.o_inst_ff !== 32'h1111_1111 || bus0.o_val_ff !== 1'b1 || bus0.o_index_ff !== 9'h086 || bus0.o_taken_ff !== 1'b1) begin
         errors++; $display("FAIL dstall_hold got inst=%h val=%b idx=%h tk=%b exp 11111111 1 086 1",
                            bus0.o_inst_ff, bus0.o_val_ff, bus0.o_index_ff, bus0.o_taken_ff); end
      dstall = 1'b0; clr_alu = 1'b0;
      bus0.i_upd_valid = 1'b0; bus1.i_upd_valid = 1'b0;
      step();
      checks++; if (bus0.o_taken_ff !== 1'b1 || bus0.o_inst_ff !== 32'h2222_2222) begin
         errors++; $display("FAIL dstall_table got tk=%b inst=%h exp 1 22222222", bus0.o_taken_ff, bus0.o_inst_ff); end
      checks++; if (bus1.o_index_ff !== 9'h055 || bus1.o_taken_ff !== 1'b1) begin
         errors++; $display("FAIL dstall_ghr got idx=%h tk=%b exp 055 1", bus1.o_index_ff, bus1.o_taken_ff); end
   endtask

   task automatic test_clear();
      clr_alu = 1'b1;
      step();
      clr_alu = 1'b0;
      checks++; if (bus0.o_inst_ff !== 32'h0 || bus0.o_pc_plus_8_ff !== 32'h8 || bus0.o_val_ff !== 1'b0 || bus0.o_index_ff !== 9'h0) begin
         errors++; $display("FAIL alu_clear got inst=%h pc8=%h val=%b idx=%h exp 0 8 0 0",
                            bus0.o_inst_ff, bus0.o_pc_plus_8_ff, bus0.o_val_ff, bus0.o_index_ff); end
      bus0.i_inst = 32'h3333_3333; bus0.i_abt = 1'b1;
      step();
      checks++; if (bus0.o_abt_ff !== 1'b1 || bus0.o_inst_ff !== 32'h3333_3333) begin
         errors++; $display("FAIL abt_load got abt=%b inst=%h exp 1 33333333", bus0.o_abt_ff, bus0.o_inst_ff); end
      st_iss = 1'b1; clr_dec = 1'b1; bus0.i_inst = 32'h4444_4444; bus0.i_abt = 1'b0;
      step();
      checks++; if (bus0.o_inst_ff !== 32'h3333_3333 || bus0.o_val_ff !== 1'b1) begin
         errors++; $display("FAIL issue_over_decclr got inst=%h val=%b exp 33333333 1", bus0.o_inst_ff, bus0.o_val_ff); end
      st_iss = 1'b0; clr_dec = 1'b0;
      dstall = 1'b1; clr_wb = 1'b1;
      step();
      dstall = 1'b0; clr_wb = 1'b0;
      checks++; if (bus0.o_val_ff !== 1'b0 || bus0.o_pc_plus_8_ff !== 32'h8 || bus0.o_abt_ff !== 1'b0) begin
         errors++; $display("FAIL wb_over_dstall got val=%b pc8=%h abt=%b exp 0 8 0", bus0.o_val_ff, bus0.o_pc_plus_8_ff, bus0.o_abt_ff); end
   endtask

   task automatic test_flush();
      int n = 0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      checks++; if (busy0 !== 1'b1 || busy1 !== 1'b1) begin errors++; $display("FAIL ready_flush got %b/%b exp 1/1", busy0, busy1); end
      for (int i = 0; i < 20; i++) step();
      rst_n = 1'b0;
      #2;
      checks++; if (busy0 !== 1'b1 || bus0.o_val_ff !== 1'b0) begin
         errors++; $display("FAIL midsweep_reset got busy=%b val=%b exp 1 0", busy0, bus0.o_val_ff); end
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 100; i++) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      while (busy0 === 1'b1 && n < 1000) begin step(); n++; end
      checks++; if (n != 512) begin errors++; $display("FAIL flush_restart_len got %0d exp 512", n); end
      bus0.i_pc = 32'h10C;
      step();
      checks++; if (bus0.o_taken_ff !== 1'b0 || bus0.o_index_ff !== 9'h086 || bus0.o_val_ff !== 1'b1) begin
         errors++; $display("FAIL reinit_lookup got tk=%b idx=%h val=%b exp 0 086 1", bus0.o_taken_ff, bus0.o_index_ff, bus0.o_val_ff); end
   endtask

   initial begin
      rst_n = 1'b0;
      {clr_wb, dstall, clr_alu, st_shf, st_iss, st_dec, clr_dec, flush} = '0;
      bus0.i_pc = '0; bus0.i_inst = '0; bus0.i_pc_plus_8 = '0; bus0.i_val = 1'b0; bus0.i_abt = 1'b0;
      bus0.i_upd_valid = 1'b0; bus0.i_upd_index = '0; bus0.i_upd_taken = 1'b0;
      bus1.i_pc = '0; bus1.i_inst = '0; bus1.i_pc_plus_8 = '0; bus1.i_val = 1'b0; bus1.i_abt = 1'b0;
      bus1.i_upd_valid = 1'b0; bus1.i_upd_index = '0; bus1.i_upd_taken = 1'b0;
      #1;
      test_reset();
      test_gshare_off();
      test_saturation_low();
      test_history();
      test_data_stall();
      test_clear();
      test_flush();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/zap_branch_predict_gshare.md
ZAP_BRANCH_PREDICT_GSHARE -- requirements
Module: zap_branch_predict_gshare

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  ENTRIES  512  counter-table depth, power of 2, 16..4096
  CTR_W  2  saturating-counter width, 1..4
  HIST_W  8  global-history width, 0..log2(ENTRIES)
  GSHARE  1  1 = index is PC XOR history; 0 = PC only
REQ-002 Ports (name, direction, width, meaning), one per line; IDX_W = log2(ENTRIES):
  i_clk  in  1  clock
  i_reset_n  in  1  asynchronous active-low reset
  i_clear_from_writeback, i_data_stall, i_clear_from_alu, i_stall_from_shifter, i_stall_from_issue, i_stall_from_decode, i_clear_from_decode  in  1 each  pipeline control
  i_flush_table  in  1  restart table initialisation
  i_pc  in  32  fetch PC (not +8)
  i_inst, i_pc_plus_8  in  32 each  fetch payload
  i_val, i_abt  in  1 each  fetch valid, instruction abort
  i_upd_valid  in  1  resolved-branch update strobe
  i_upd_index  in  IDX_W  index carried with the resolved branch
  i_upd_taken  in  1  actual branch outcome
  o_inst_ff, o_pc_plus_8_ff  out  32 each  registered payload
  o_val_ff, o_abt_ff  out  1 each  registered valid, abort
  o_taken_ff  out  1  registered prediction
  o_index_ff  out  IDX_W  index used for the prediction
  o_init_busy  out  1  table initialisation in progress

Function
REQ-003 Lookup index SHALL be i_pc[IDX_W:1] XOR {zero-extended ghr} when GSHARE=1, else i_pc[IDX_W:1].
REQ-004 Prediction SHALL be the MSB of the addressed counter, read combinationally from the pre-update table value.
REQ-005 Output-register priority SHALL be, highest first: writeback clear, data stall (hold), ALU clear, shifter stall (hold), issue stall (hold), decode stall (hold), decode clear, then load.
REQ-006 A clear SHALL set o_inst_ff=0, o_val_ff=0, o_abt_ff=0, o_pc_plus_8_ff=8, o_taken_ff=0, o_index_ff=0.
REQ-007 A load SHALL capture all fetch payload, the prediction and the lookup index; latency is 1 cycle.
REQ-008 While o_init_busy=1, a load SHALL force o_val_ff=0 and o_taken_ff=0.
REQ-009 On i_upd_valid=1 and i_data_stall=0, counter[i_upd_index] SHALL increment if i_upd_taken=1, else decrement, saturating at 2^CTR_W-1 and 0.
REQ-010 On the same qualified update, ghr SHALL shift left by one with i_upd_taken entering bit 0; ghr is absent when HIST_W=0.
REQ-011 State machine: INIT -> READY when the sweep counter reaches ENTRIES-1; READY -> INIT on i_flush_table=1.
REQ-012 In INIT, one entry per cycle SHALL be written to weakly-not-taken (2^(CTR_W-1)-1, or 0 when CTR_W=1), and ghr SHALL be held at 0.
REQ-013 Updates arriving in INIT SHALL be dropped.
REQ-014 i_flush_table asserted during INIT SHALL restart the sweep at index 0.
REQ-015 o_init_busy SHALL equal (state==INIT), registered.
REQ-016 A lookup and an update to the same index in the same cycle SHALL predict from the old value and commit the update.

Reset
REQ-017 i_reset_n=0 SHALL asynchronously force state=INIT, sweep counter=0, ghr=0, and all outputs to the REQ-006 clear values with o_init_busy=1; table contents are not reset (INIT rewrites them).
REQ-018 Reset asserted mid-sweep or mid-operation SHALL restart initialisation from index 0 on release.

Structure
REQ-019 Counter-state encodings (SNT/WNT/WT/ST for CTR_W=2) and the INIT/READY state constants SHALL live in a shared package zap_bp_pkg.
REQ-020 The counter table with its saturating update and sweep writes SHALL be one sub-module, zap_bp_counter_ram (1 read port, 1 write port).

Verification
REQ-021 Reset release, ENTRIES=512 -> o_init_busy=1 for 512 cycles, then 0; all loads in that window have o_val_ff=0.
REQ-022 GSHARE=0, pc=0x10C, 3 updates with taken=1 at index 0x86 -> counter 1->2->3->3; the next lookup at 0x10C gives o_taken_ff=1 and o_index_ff=0x86.
REQ-023 Counter at 0, update with taken=0 -> stays 0; CTR_W=3 at 7, update with taken=1 -> stays 7.
REQ-024 GSHARE=1, HIST_W=4, updates taken 1,0,1,1 -> ghr=0xB; pc=0x20 looks up index 0x10^0xB=0x1B.
REQ-025 i_data_stall=1 with i_upd_valid=1 and i_clear_from_alu=1 -> outputs, table and ghr all unchanged.
REQ-026 i_flush_table pulsed at sweep index 100 -> sweep restarts at 0; o_init_busy stays high a further 512 cycles.
